pq_sort_ctrl: RTL

- Parametrised control engine for the QuickQ sorted-array priority queue. Successor to the single-purpose IDLE/advance-address/swap controller.
- Owns occupancy, insertion ordering (compare + shift), O(1) pop and flush.
- Drives an external register-file RAM with one combinational read port and one write port. Key compare is internal, so no external comparator result is needed.
- Sits between the queue's client push/pop handshakes and the storage array.

---
 rtl/pq_sort_ctrl_if.sv | 48 ++++
 rtl/pq_sort_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pq_sort_ctrl_if.sv
// Client handshake, status and storage-port bundle for the QuickQ sort controller.
interface pq_sort_ctrl_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned KEY_W  = 16,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = KEY_W + DATA_W;

  // client push side
  logic              push_valid;
  logic [KEY_W-1:0]  push_key;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  // client pop side
  logic              pop_valid;
  logic              pop_ready;
  logic [KEY_W-1:0]  head_key;
  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  // control and status
  logic              flush;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              busy;
  // storage array port
  logic [AW-1:0]     mem_raddr;
  logic [EW-1:0]     mem_rdata;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [EW-1:0]     mem_wdata;

  // Controller side
  modport slave (
    input  push_valid, push_key, push_data, pop_valid, flush, mem_rdata,
    output push_ready, pop_ready, head_key, head_data, head_valid,
           count, full, empty, busy, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  // Client / storage side
  modport master (
    output push_valid, push_key, push_data, pop_valid, flush, mem_rdata,
    input  push_ready, pop_ready, head_key, head_data, head_valid,
           count, full, empty, busy, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/pq_sort_ctrl.sv
// Sorted-array priority queue controller: insertion by compare/shift, O(1) pop, flush.
// Entries live at addr 0..count-1 in ascending priority; addr count-1 is the head.
module pq_sort_ctrl #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned KEY_W  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MODE   = 0
) (
  input  logic          clk,
  input  logic          rst,
  pq_sort_ctrl_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = KEY_W + DATA_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCmp   = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StPlace = 2'd3;

  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [AW-1:0] IdxOne = AW'(1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [EW-1:0]     rd_q, rd_d;

  logic              idle, is_empty, is_full;
  logic              pop_fire, push_fire, beats;
  logic [CW-1:0]     cnt_m1;
  logic [AW-1:0]     idx_m1;
  logic [KEY_W-1:0]  rd_key;

  assign idle     = (state_q == StIdle);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign cnt_m1   = count_q - CntOne;
  assign idx_m1   = idx_q - IdxOne;
  assign rd_key   = bus.mem_rdata[EW-1:DATA_W];
  // Strict unsigned compare: equal keys never beat, so the newer entry lands below (FIFO ties).
  assign beats    = (MODE == 0) ? (key_q < rd_key) : (key_q > rd_key);

  // Pop outranks push in the same cycle; flush blocks both.
  assign bus.pop_ready  = idle & ~is_empty & ~bus.flush;
  assign bus.push_ready = idle & ~is_full & ~bus.pop_valid & ~bus.flush;
  assign pop_fire       = bus.pop_valid & bus.pop_ready;
  assign push_fire      = bus.push_valid & bus.push_ready;

  assign bus.head_valid = idle & ~is_empty;
  assign bus.head_key   = bus.mem_rdata[EW-1:DATA_W];
  assign bus.head_data  = bus.mem_rdata[DATA_W-1:0];
  assign bus.count      = count_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.busy       = ~idle;

  // Storage port: head read in IDLE, neighbour read in CMP, writes only in SHIFT/PLACE.
  always_comb begin
    bus.mem_raddr = '0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      StIdle:  if (!is_empty) bus.mem_raddr = cnt_m1[AW-1:0];
      StCmp:   bus.mem_raddr = idx_m1;
      StShift: begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = idx_q;
        bus.mem_wdata = rd_q;
      end
      StPlace: begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = idx_q;
        bus.mem_wdata = {key_q, data_q};
      end
      default: ;
    endcase
  end

  // Next-state: insertion walks idx down from count, shifting until the new key beats a neighbour.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    key_d   = key_q;
    data_d  = data_q;
    rd_d    = rd_q;
    case (state_q)
      StIdle: begin
        if (pop_fire) begin
          count_d = cnt_m1;
        end else if (push_fire) begin
          key_d   = bus.push_key;
          data_d  = bus.push_data;
          idx_d   = count_q[AW-1:0];
          state_d = is_empty ? StPlace : StCmp;
        end
      end
      StCmp: begin
        rd_d    = bus.mem_rdata;
        state_d = beats ? StPlace : StShift;
      end
      StShift: begin
        idx_d   = idx_m1;
        state_d = (idx_m1 == '0) ? StPlace : StCmp;
      end
      StPlace: begin
        count_d = count_q + CntOne;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush aborts any insert in progress before its PLACE.
    if (bus.flush) begin
      state_d = StIdle;
      count_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
    end
  end
endmodule
